rim_bfs_param: RTL and testbench

//  Parametrised rat-in-maze solver, successor to the fixed 8x8 right/down RIM core.
//  - Accepts an NxN maze, one row per cycle.
//  - Finds a shortest 4-direction path (up/down/left/right) from (0,0) to (N-1,N-1)
//    by parallel flood fill from the goal, then walks back from the start.
//  - Streams the path one cell per cycle; path length varies by maze.
//  - Reports out_fail when no path exists.

---
 rtl/rim_bfs_param_if.sv | 24 ++
 rtl/rim_bfs_param.sv | 178 +++++++++++++++++
 tb/tb_rim_bfs_param.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rim_bfs_param_if.sv
// Maze-in / path-out bundle for the parametrised rat-in-maze solver.
// The master drives maze rows. The slave returns path cells and the fail pulse.
interface rim_bfs_param_if #(
  parameter int N = 8
);
  localparam int RW = $clog2(N);

  logic          in_valid;
  logic [N-1:0]  maze;
  logic          out_valid;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          out_fail;

  modport master (
    output in_valid, maze,
    input  out_valid, out_row, out_col, out_fail
  );

  modport slave (
    input  in_valid, maze,
    output out_valid, out_row, out_col, out_fail
  );
endinterface

// File: rtl/rim_bfs_param.sv
// Shortest-path rat-in-maze solver for an NxN grid.
// It floods distances outward from the goal, one wave per cycle, then walks back from the start.
module rim_bfs_param #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rim_bfs_param_if.slave  bus
);
  localparam int RW   = $clog2(N);
  localparam int DW   = $clog2(N * N);
  localparam int NC   = N * N;
  localparam int GOAL = NC - 1;
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLOOD, WALK, FAIL} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] wave_q, wave_d;
  logic [NC-1:0] open_q, open_d;
  logic [NC-1:0] vis_q, vis_d;
  logic [DW-1:0] dist_q [NC];
  logic [DW-1:0] dist_d [NC];
  logic [RW-1:0] cur_row_q, cur_row_d;
  logic [RW-1:0] cur_col_q, cur_col_d;
  logic          out_valid_q, out_valid_d;
  logic          out_fail_q, out_fail_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [RW-1:0] out_col_q, out_col_d;

  // Frontier = cells labelled on the previous wave; shifts deliver it to the 4 neighbours.
  logic [NC-1:0] front, col_first, col_last, mark;

  for (genvar gi = 0; gi < NC; gi++) begin : g_cell
    assign front[gi]     = vis_q[gi] && (dist_q[gi] == wave_q);
    assign col_first[gi] = ((gi % N) == 0);
    assign col_last[gi]  = ((gi % N) == N - 1);
  end

  assign mark = open_q & ~vis_q &
                ((front << N) | (front >> N) |
                 ((front << 1) & ~col_first) | ((front >> 1) & ~col_last));

  // Neighbour indices are clamped to the current cell at the border, so they are always in range.
  logic [DW-1:0] cur_idx, dn_idx, rt_idx, up_idx, lf_idx, dm1;
  logic          dn_ok, rt_ok, up_ok, lf_ok;

  assign cur_idx = DW'(int'(cur_row_q) * N + int'(cur_col_q));
  assign dn_idx  = (cur_row_q != LAST) ? DW'(int'(cur_idx) + N) : cur_idx;
  assign up_idx  = (cur_row_q != '0)   ? DW'(int'(cur_idx) - N) : cur_idx;
  assign rt_idx  = (cur_col_q != LAST) ? DW'(int'(cur_idx) + 1) : cur_idx;
  assign lf_idx  = (cur_col_q != '0)   ? DW'(int'(cur_idx) - 1) : cur_idx;
  assign dm1     = dist_q[cur_idx] - DW'(1);

  assign dn_ok = (cur_row_q != LAST) && vis_q[dn_idx] && (dist_q[dn_idx] == dm1);
  assign rt_ok = (cur_col_q != LAST) && vis_q[rt_idx] && (dist_q[rt_idx] == dm1);
  assign up_ok = (cur_row_q != '0)   && vis_q[up_idx] && (dist_q[up_idx] == dm1);
  assign lf_ok = (cur_col_q != '0)   && vis_q[lf_idx] && (dist_q[lf_idx] == dm1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    wave_d      = wave_q;
    open_d      = open_q;
    vis_d       = vis_q;
    dist_d      = dist_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    out_valid_d = 1'b0;
    out_fail_d  = 1'b0;
    out_row_d   = '0;
    out_col_d   = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int c = 0; c < N; c++) begin
            open_d[DW'(c)] = bus.maze[RW'(N - 1 - c)];
          end
          vis_d   = '0;
          row_d   = RW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.in_valid) begin
          state_d = IDLE;
        end else begin
          for (int c = 0; c < N; c++) begin
            open_d[DW'(int'(row_q) * N + c)] = bus.maze[RW'(N - 1 - c)];
          end
          if (row_q == LAST) begin
            vis_d[GOAL]  = 1'b1;
            dist_d[GOAL] = '0;
            wave_d       = '0;
            // Row 0 is already stored; the goal bit arrives on this row as maze[0].
            state_d      = (!open_q[0] || !bus.maze[0]) ? FAIL : FLOOD;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      FLOOD: begin
        for (int j = 0; j < NC; j++) begin
          if (mark[DW'(j)]) begin
            vis_d[DW'(j)]  = 1'b1;
            dist_d[DW'(j)] = wave_q + DW'(1);
          end
        end
        if (mark == '0) begin
          state_d = FAIL;
        end else if (mark[0]) begin
          state_d   = WALK;
          cur_row_d = '0;
          cur_col_d = '0;
        end else begin
          wave_d = wave_q + DW'(1);
        end
      end
      WALK: begin
        out_valid_d = 1'b1;
        out_row_d   = cur_row_q;
        out_col_d   = cur_col_q;
        if (cur_row_q == LAST && cur_col_q == LAST) begin
          state_d = IDLE;
        end else if (dn_ok) begin
          cur_row_d = cur_row_q + RW'(1);
        end else if (rt_ok) begin
          cur_col_d = cur_col_q + RW'(1);
        end else if (up_ok) begin
          cur_row_d = cur_row_q - RW'(1);
        end else if (lf_ok) begin
          cur_col_d = cur_col_q - RW'(1);
        end
      end
      FAIL: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      wave_q      <= '0;
      open_q      <= '0;
      vis_q       <= '0;
      dist_q      <= '{default: '0};
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_fail_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      wave_q      <= wave_d;
      open_q      <= open_d;
      vis_q       <= vis_d;
      dist_q      <= dist_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      out_valid_q <= out_valid_d;
      out_fail_q  <= out_fail_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_fail  = out_fail_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
endmodule

// File: tb/tb_rim_bfs_param.sv
// Scoreboard bench for rim_bfs_param: a queue-based BFS model predicts every path cell or fail pulse.
// Monitors on the falling edge compare the N=8 and N=4 instances against that model.
module tb_rim_bfs_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rim_bfs_param_if #(.N(8)) if8 ();
  rim_bfs_param_if #(.N(4)) if4 ();

  rim_bfs_param #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  rim_bfs_param #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  typedef struct {
    int r;
    int c;
    bit fail;
    int cyc;   // -1: timing not predicted
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   total = 0;
  int   bad = 0;
  int   maze [16][16];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(bit big, exp_t e);
    if (big) q8.push_back(e);
    else     q4.push_back(e);
  endfunction

  // Golden model: breadth-first search from the goal, then walk down the distances from the start.
  function automatic void model(int n, int c0, bit big);
    int d [16][16];
    int qr[$];
    int qc[$];
    int dr[4] = '{1, 0, -1, 0};
    int dc[4] = '{0, 1, 0, -1};
    int r, c, nr, nc, dd;
    exp_t e;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) d[i][j] = -1;
    if (maze[0][0] == 0 || maze[n-1][n-1] == 0) begin
      e = '{0, 0, 1'b1, c0};
      push(big, e);
      return;
    end
    d[n-1][n-1] = 0;
    qr.push_back(n - 1);
    qc.push_back(n - 1);
    while (qr.size() != 0) begin
      r = qr.pop_front();
      c = qc.pop_front();
      for (int k = 0; k < 4; k++) begin
        nr = r + dr[k];
        nc = c + dc[k];
        if (nr >= 0 && nr < n && nc >= 0 && nc < n && maze[nr][nc] != 0 && d[nr][nc] < 0) begin
          d[nr][nc] = d[r][c] + 1;
          qr.push_back(nr);
          qc.push_back(nc);
        end
      end
    end
    if (d[0][0] < 0) begin
      e = '{0, 0, 1'b1, -1};
      push(big, e);
      return;
    end
    dd = d[0][0];
    r = 0;
    c = 0;
    for (int i = 0; i <= dd; i++) begin
      e = '{r, c, 1'b0, c0 + dd + 1 + i};
      push(big, e);
      if (i == dd) break;
      for (int k = 0; k < 4; k++) begin
        nr = r + dr[k];
        nc = c + dc[k];
        if (nr >= 0 && nr < n && nc >= 0 && nc < n && d[nr][nc] == d[r][c] - 1) begin
          r = nr;
          c = nc;
          break;
        end
      end
    end
  endfunction

  function automatic void mon(bit big, logic v, logic f, int r, int c);
    exp_t  e;
    string t = big ? "8" : "4";
    int    qs = big ? q8.size() : q4.size();
    chk({"excl", t}, int'(v & f), 0);
    if (!v) begin
      chk({"idle_row", t}, r, 0);
      chk({"idle_col", t}, c, 0);
    end
    if (v || f) begin
      if (qs == 0) begin
        chk({"spurious", t}, int'(v) + int'(f), 0);
      end else begin
        if (big) e = q8.pop_front();
        else     e = q4.pop_front();
        chk({"fail_flag", t}, int'(f), int'(e.fail));
        if (!e.fail) begin
          chk({"cell_row", t}, r, e.r);
          chk({"cell_col", t}, c, e.c);
        end
        if (e.cyc >= 0) chk({"timing", t}, cyc, e.cyc);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      mon(1'b1, if8.out_valid, if8.out_fail, int'(if8.out_row), int'(if8.out_col));
      mon(1'b0, if4.out_valid, if4.out_fail, int'(if4.out_row), int'(if4.out_col));
    end
  end

  task automatic drive(input int n, input logic v, input logic [15:0] row);
    if (n == 8) begin
      if8.in_valid = v;
      if8.maze     = row[7:0];
    end else begin
      if4.in_valid = v;
      if4.maze     = row[3:0];
    end
  endtask

  // Called at posedge+1; returns at posedge+1. abort_after >= 0 drops in_valid after that row.
  task automatic send(input int n, input int abort_after);
    logic [15:0] row;
    for (int r = 0; r < n; r++) begin
      row = '0;
      for (int c = 0; c < n; c++) row[n-1-c] = (maze[r][c] != 0);
      drive(n, 1'b1, row);
      @(posedge clk);
      #1;
      if (r == abort_after) begin
        drive(n, 1'b0, '0);
        return;
      end
    end
    drive(n, 1'b0, '0);
    model(n, cyc, n == 8);
  endtask

  task automatic drain(input bit big, input string name);
    int k = 0;
    while ((big ? q8.size() : q4.size()) != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk({"drain_", name}, big ? q8.size() : q4.size(), 0);
    if (big) q8.delete();
    else     q4.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int pct);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        maze[r][c] = (r < n && c < n && $urandom_range(0, 99) < pct) ? 1 : 0;
  endtask

  initial begin
    int nv;
    int k;
    drive(8, 1'b0, '0);
    drive(4, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid8", int'(if8.out_valid), 0);
    chk("rst_fail8",  int'(if8.out_fail), 0);
    chk("rst_row8",   int'(if8.out_row), 0);
    chk("rst_col8",   int'(if8.out_col), 0);
    chk("rst_valid4", int'(if4.out_valid), 0);
    chk("rst_fail4",  int'(if4.out_fail), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-open 8x8: down the first column, then along the last row.
    fill(8, 100);
    send(8, -1);
    drain(1'b1, "open8");

    // Serpentine: walls at columns 1, 3, 5 with gaps bottom, top, bottom.
    fill(8, 100);
    for (int r = 0; r < 8; r++) begin
      maze[r][1] = (r == 7) ? 1 : 0;
      maze[r][3] = (r == 0) ? 1 : 0;
      maze[r][5] = (r == 7) ? 1 : 0;
    end
    send(8, -1);
    drain(1'b1, "serpentine");

    // Row 4 walled off: no path.
    fill(8, 100);
    for (int c = 0; c < 8; c++) maze[4][c] = 0;
    send(8, -1);
    drain(1'b1, "row4wall");

    // Start cell is a wall (row 0 = 8'h7F).
    fill(8, 100);
    maze[0][0] = 0;
    send(8, -1);
    drain(1'b1, "startwall");

    // Reset asserted during the third WALK cycle.
    fill(8, 100);
    send(8, -1);
    nv = 0;
    k = 0;
    while (nv < 3 && k < 200) begin
      @(posedge clk);
      #2;
      if (if8.out_valid) nv++;
      k++;
    end
    chk("walk3_reached", nv, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(if8.out_valid), 0);
    chk("midrst_row",   int'(if8.out_row), 0);
    chk("midrst_col",   int'(if8.out_col), 0);
    q8.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8, -1);
    drain(1'b1, "after_reset");

    // N=4: in_valid toggled during WALK must be ignored, then a second maze back-to-back.
    fill(4, 100);
    send(4, -1);
    k = 0;
    while (!if4.out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("walk4_started", int'(if4.out_valid), 1);
    repeat (3) begin
      drive(4, 1'b1, 16'($urandom));
      @(posedge clk);
      #1;
    end
    drive(4, 1'b0, '0);
    drain(1'b0, "open4_a");
    send(4, -1);
    drain(1'b0, "open4_b");

    // Aborted load followed by a full maze.
    fill(4, 50);
    send(4, 1);
    @(posedge clk);
    #1;
    fill(4, 100);
    send(4, -1);
    drain(1'b0, "abort4");

    // Random mazes on both sizes.
    for (int i = 0; i < 100; i++) begin
      fill(4, 70);
      if ($urandom_range(0, 9) != 0) begin
        maze[0][0] = 1;
        maze[3][3] = 1;
      end
      send(4, -1);
      drain(1'b0, "rand4");
    end
    for (int i = 0; i < 25; i++) begin
      fill(8, 72);
      if ($urandom_range(0, 9) != 0) begin
        maze[0][0] = 1;
        maze[7][7] = 1;
      end
      send(8, -1);
      drain(1'b1, "rand8");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end
endmodule
